// File: rtl/enc_stage_2.sv
`default_nettype none
// ============================================================================
// Module   : enc_stage_2
// Purpose  : Completes the extended-Hamming codeword with its overall even
//            parity bit and buffers results in a 2-entry FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module enc_stage_2 #(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] in_codeword,
    input  logic [1:0]                    in_work_mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] out_codeword,
    output logic [1:0]                    out_work_mod,
    output logic                          err_mode,
    output logic [CNT_WIDTH-1:0]          word_count
);

    localparam int                          c_W   = MAX_CODEWORD_WIDTH;
    localparam logic [c_W-1:0]              c_ONE = {{(c_W-1){1'b0}}, 1'b1};
    localparam logic [c_W-1:0]              c_ALL = {c_W{1'b1}};
    localparam logic [1:0]                  c_MODE_ILLEGAL = 2'b11;

    logic [c_W-1:0] w_len_mask;
    logic [c_W-1:0] w_pslot;
    logic [c_W-1:0] w_body;
    logic [c_W-1:0] w_completed;
    logic           w_parity;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;

    logic [c_W-1:0]       r_data [2];
    logic [1:0]           r_mode [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_occ;
    logic                 r_err_mode;
    logic [CNT_WIDTH-1:0] r_word_count;

    // Code length mask and overall-parity slot for the selected mode
    always_comb begin
        w_len_mask = c_ALL >> (c_W - 32);
        w_pslot    = c_ONE << 5;
        case (in_work_mod)
            2'b00: begin
                w_len_mask = c_ALL >> (c_W - 8);
                w_pslot    = c_ONE << 3;
            end
            2'b01: begin
                w_len_mask = c_ALL >> (c_W - 16);
                w_pslot    = c_ONE << 4;
            end
            default: begin
                w_len_mask = c_ALL >> (c_W - 32);
                w_pslot    = c_ONE << 5;
            end
        endcase
    end

    assign w_body      = in_codeword & w_len_mask & ~w_pslot;
    assign w_parity    = ^w_body;
    assign w_completed = w_body | (w_parity ? w_pslot : '0);

    assign in_ready = !rst && (r_occ < 2'd2);
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && (in_work_mod != c_MODE_ILLEGAL);
    assign out_valid = (r_occ != 2'd0);
    assign w_pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_mode[0] <= '0;
            r_mode[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_occ     <= 2'd0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_completed;
                r_mode[r_wr_ptr] <= in_work_mod;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_mode   <= 1'b0;
            r_word_count <= '0;
        end else begin
            if (w_accept && (in_work_mod == c_MODE_ILLEGAL)) begin
                r_err_mode <= 1'b1;
            end
            if (w_push && (r_word_count != {CNT_WIDTH{1'b1}})) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

    // Empty FIFO reads as zero regardless of stale storage contents
    assign out_codeword = out_valid ? r_data[r_rd_ptr] : '0;
    assign out_work_mod = out_valid ? r_mode[r_rd_ptr] : 2'b00;
    assign err_mode     = r_err_mode;
    assign word_count   = r_word_count;

endmodule
`default_nettype wire
